// File: rtl/hs4_pkg.sv
// Shared types and defaults for the 4-phase bundled-data bridges.
package hs4_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    ACK_HI   = 2'd2
  } state_t;

  localparam int HS4_DATA_W      = 8;
  localparam int HS4_SYNC_STAGES = 2;
  localparam int HS4_DEPTH       = 2;

  function automatic int fill_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int HS4_FILL_W = fill_w(HS4_DEPTH);

endpackage

// File: rtl/hs4_rx_bridge_if.sv
// Handshake side (req/data/ack) and stream side (valid/ready/data) of the rx bridge.
interface hs4_rx_bridge_if
  import hs4_pkg::*;
#(
  parameter int DATA_W = HS4_DATA_W
) ();

  logic              in_req;
  logic [DATA_W-1:0] in_data;
  logic              in_ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_req,
    input  in_data,
    output in_ack,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_req,
    output in_data,
    input  in_ack,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/hs4_sync.sv
// Multi-flop single-bit synchroniser, async active-high reset to 0.
module hs4_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // shift chain; only sync_r[0] may go metastable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/hs4_rx_bridge.sv
// Receives 4-phase bundled-data tokens, acks them, and buffers them onto a valid/ready stream.
module hs4_rx_bridge
  import hs4_pkg::*;
#(
  parameter int DATA_W      = HS4_DATA_W,
  parameter int SYNC_STAGES = HS4_SYNC_STAGES,
  parameter int DEPTH       = HS4_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  hs4_rx_bridge_if.slave         bus,
  output logic [$clog2(DEPTH):0] fill,
  output logic [7:0]             tok_cnt
);

  localparam int                PTR_W  = $clog2(DEPTH);
  localparam int                FILL_W = fill_w(DEPTH);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(DEPTH);
  localparam logic [2:0]        SETTLE = 3'(SYNC_STAGES);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               req_s;
  logic               push_s;
  logic               pop_s;
  logic               settled_s;
  logic [2:0]         settle_r;
  logic               ack_r;
  logic               valid_r;
  logic [DATA_W-1:0]  head_r;
  logic [DATA_W-1:0]  head_nxt_s;
  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   rd_nxt_s;
  logic [FILL_W-1:0]  fill_r;
  logic [FILL_W-1:0]  fill_nxt_s;
  logic [7:0]         tok_r;

  hs4_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.in_req),
    .q   (req_s)
  );

  // The synchroniser reads 0 right after reset regardless of in_req, so a
  // low req_s is trusted only once the chain has refilled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_r <= 3'd0;
    end else if (!settled_s) begin
      settle_r <= settle_r + 3'd1;
    end else begin
      settle_r <= settle_r;
    end
  end

  assign settled_s = (settle_r == SETTLE);
  assign pop_s     = valid_r && bus.out_ready;

  // handshake FSM: next state and push decision
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    case (state_r)
      WAIT_LOW: begin
        if (settled_s && !req_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_LOW;
        end
      end
      IDLE: begin
        if (req_s && (fill_r != FULL)) begin
          push_s      = 1'b1;
          state_nxt_s = ACK_HI;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACK_HI;
        end
      end
      default: begin
        state_nxt_s = WAIT_LOW;
      end
    endcase
  end

  // FIFO bookkeeping; the head register is preloaded with whatever will be at the front next cycle
  always_comb begin
    rd_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   fill_nxt_s = fill_r + FILL_W'(1);
      2'b01:   fill_nxt_s = fill_r - FILL_W'(1);
      default: fill_nxt_s = fill_r;
    endcase
    if (push_s && (wr_ptr_r == rd_nxt_s)) begin
      head_nxt_s = bus.in_data;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // state, ack and token counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= WAIT_LOW;
      ack_r   <= 1'b0;
      tok_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= (state_nxt_s == ACK_HI);
      tok_r   <= push_s ? (tok_r + 8'd1) : tok_r;
    end
  end

  // FIFO storage, pointers and registered stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= '0;
      valid_r  <= 1'b0;
      head_r   <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.in_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r <= rd_nxt_s;
      fill_r   <= fill_nxt_s;
      valid_r  <= (fill_nxt_s != '0);
      if (fill_nxt_s != '0) begin
        head_r <= head_nxt_s;
      end
    end
  end

  assign bus.in_ack    = ack_r;
  assign bus.out_valid = valid_r;
  assign bus.out_data  = head_r;
  assign fill          = fill_r;
  assign tok_cnt       = tok_r;

endmodule
